// File: rtl/csr_row_sequencer.sv
// csr_row_sequencer: walks the CSR row-pointer RAM and issues one command per
// nonzero (element index, row, last flag) to the column/S/vector/MAC pipeline
// over a valid/ready handshake. Rows with no nonzeros produce a single command
// flagged empty, so d[row] still gets a zero written back.
module csr_row_sequencer #(
   parameter int NROWS = 16,
   parameter int ROW_W = 4,
   parameter int NNZ_W = 7,
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [ROW_W:0]   rp_addr,
   input  logic [NNZ_W-1:0] rp_data,
   output logic             nz_valid,
   input  logic             nz_ready,
   output logic [NNZ_W-1:0] nz_idx,
   output logic [ROW_W-1:0] nz_row,
   output logic             nz_last,
   output logic             nz_empty,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [ROW_W:0]   ONE_ADDR = (ROW_W+1)'(1);
   localparam logic [ROW_W-1:0] ONE_ROW  = ROW_W'(1);
   localparam logic [NNZ_W-1:0] ONE_IDX  = NNZ_W'(1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BASE,
      S_PTR,
      S_CHK,
      S_ISSUE,
      S_EMPTY,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [ROW_W-1:0] row;
   logic [NNZ_W-1:0] base;
   logic [NNZ_W-1:0] cur;
   logic [NNZ_W-1:0] row_end;
   logic             first;
   logic             row_bad;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   logic             accept;
   logic             on_last_row;

   assign on_last_row = (row == LAST_ROW);
   assign accept      = nz_valid && nz_ready;
   assign nz_row      = row;
   assign err         = err_q;
   assign cycle_count = cnt_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and command/status outputs, all derived from registers
   // so the command stays stable while the datapath stalls.
   always_comb begin
      state_nxt = state;
      rp_addr   = '0;
      nz_valid  = 1'b0;
      nz_idx    = cur;
      nz_last   = 1'b0;
      nz_empty  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;

      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = S_BASE;
            end
         end

         S_BASE: begin
            state_nxt = S_PTR;
         end

         S_PTR: begin
            rp_addr   = {1'b0, row} + ONE_ADDR;
            state_nxt = S_CHK;
         end

         S_CHK: begin
            if (rp_data > base) begin
               state_nxt = S_ISSUE;
            end else begin
               state_nxt = S_EMPTY;
            end
         end

         S_ISSUE: begin
            nz_valid = 1'b1;
            nz_idx   = cur;
            nz_last  = (cur == (row_end - ONE_IDX));
            if (nz_ready && nz_last) begin
               state_nxt = on_last_row ? S_DONE : S_PTR;
            end
         end

         S_EMPTY: begin
            nz_valid = 1'b1;
            nz_idx   = base;
            nz_last  = 1'b1;
            nz_empty = 1'b1;
            if (nz_ready) begin
               state_nxt = on_last_row ? S_DONE : S_PTR;
            end
         end

         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) begin
               state_nxt = S_BASE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Row walk registers: row index, window [base, end) and the running element.
   // A row whose end pointer is below its start keeps the old base, so the
   // following row is measured from the last consistent pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         row     <= '0;
         base    <= '0;
         cur     <= '0;
         row_end <= '0;
         first   <= 1'b0;
         row_bad <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  err_q <= 1'b0;
                  row   <= '0;
               end
            end

            S_BASE: begin
               first <= 1'b1;
            end

            S_PTR: begin
               if (first) begin
                  base <= rp_data;
                  cur  <= rp_data;
               end
            end

            S_CHK: begin
               row_end <= rp_data;
               row_bad <= (rp_data < base);
               if (rp_data < base) begin
                  err_q <= 1'b1;
               end
            end

            S_ISSUE: begin
               if (accept) begin
                  if (!nz_last) begin
                     cur <= cur + ONE_IDX;
                  end else if (!on_last_row) begin
                     row   <= row + ONE_ROW;
                     base  <= row_end;
                     cur   <= row_end;
                     first <= 1'b0;
                  end
               end
            end

            S_EMPTY: begin
               if (accept && !on_last_row) begin
                  row   <= row + ONE_ROW;
                  first <= 1'b0;
                  if (row_bad) begin
                     base <= cur;
                  end else begin
                     base <= row_end;
                     cur  <= row_end;
                  end
               end
            end

            default: begin
            end
         endcase
      end
   end

   // Busy-cycle counter: cleared by a run request, saturating, frozen in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (!busy && start) begin
         cnt_q <= '0;
      end else if (busy && (cnt_q != '1)) begin
         cnt_q <= cnt_q + ONE_CNT;
      end
   end

endmodule

// File: tb/tb_csr_row_sequencer.sv
// tb_csr_row_sequencer: drives csr_row_sequencer with row-pointer tables and
// several nz_ready patterns, compares every command against a list built
// directly from the CSR row-pointer semantics.
module tb_csr_row_sequencer;

   localparam int NROWS = 16;
   localparam int ROW_W = 4;
   localparam int NNZ_W = 7;
   localparam int CNT_W = 12;

   typedef struct packed {
      logic [NNZ_W-1:0] idx;
      logic [ROW_W-1:0] row;
      logic             last;
      logic             empty;
   } cmd_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [ROW_W:0]   rp_addr;
   logic [NNZ_W-1:0] rp_data = '0;
   logic             nz_valid;
   logic             nz_ready = 1'b0;
   logic [NNZ_W-1:0] nz_idx;
   logic [ROW_W-1:0] nz_row;
   logic             nz_last;
   logic             nz_empty;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] cycle_count;

   csr_row_sequencer #(
      .NROWS(NROWS),
      .ROW_W(ROW_W),
      .NNZ_W(NNZ_W),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .rp_addr(rp_addr),
      .rp_data(rp_data),
      .nz_valid(nz_valid),
      .nz_ready(nz_ready),
      .nz_idx(nz_idx),
      .nz_row(nz_row),
      .nz_last(nz_last),
      .nz_empty(nz_empty),
      .busy(busy),
      .done(done),
      .err(err),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   int   ptr [0:NROWS];
   cmd_t exp_q[$];
   int   exp_n;
   int   exp_err;
   int   total = 0;
   int   bad = 0;
   int   accepts = 0;
   int   stalls = 0;
   int   mode = 0;
   int   pat = 0;
   bit   mon_en = 1'b0;
   bit   prev_stall = 1'b0;
   cmd_t prev_cmd;

   // Synchronous row-pointer RAM: data appears the cycle after the address.
   initial begin
      forever begin
         @(posedge clk);
         rp_data <= NNZ_W'(ptr[rp_addr]);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Expected command stream: each row r covers elements [ptr[r], ptr[r+1]);
   // an empty or inverted row yields one empty command at the current base,
   // and an inverted row leaves the base where it was.
   task automatic build_model();
      int   b;
      int   e;
      cmd_t c;
      exp_q.delete();
      exp_err = 0;
      b = ptr[0];
      for (int r = 0; r < NROWS; r++) begin
         e = ptr[r+1];
         if (e > b) begin
            for (int i = b; i < e; i++) begin
               c.idx   = NNZ_W'(i);
               c.row   = ROW_W'(r);
               c.last  = (i == e - 1);
               c.empty = 1'b0;
               exp_q.push_back(c);
            end
            b = e;
         end else begin
            if (e < b) exp_err = 1;
            c.idx   = NNZ_W'(b);
            c.row   = ROW_W'(r);
            c.last  = 1'b1;
            c.empty = 1'b1;
            exp_q.push_back(c);
         end
      end
      exp_n = exp_q.size();
   endtask

   // Ready driver and per-cycle command checker (mid-cycle, away from posedge).
   initial begin
      cmd_t got;
      forever begin
         @(negedge clk);
         case (mode)
            0:       nz_ready = 1'b1;
            1:       nz_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
            default: nz_ready = 1'($urandom_range(0, 1));
         endcase
         pat++;
         #1;
         if (mon_en) begin
            got = {nz_idx, nz_row, nz_last, nz_empty};
            if (nz_valid) begin
               chk("busy_with_valid", 32'(busy), 32'd1);
               if (prev_stall) chk("stall_hold", 32'(got), 32'(prev_cmd));
               if (exp_q.size() == 0) begin
                  chk("cmd_extra", 32'(nz_valid), 32'd0);
               end else begin
                  chk("cmd_idx", 32'(nz_idx), 32'(exp_q[0].idx));
                  chk("cmd_row", 32'(nz_row), 32'(exp_q[0].row));
                  chk("cmd_last", 32'(nz_last), 32'(exp_q[0].last));
                  chk("cmd_empty", 32'(nz_empty), 32'(exp_q[0].empty));
               end
               if (nz_ready) begin
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
                  accepts++;
                  prev_stall = 1'b0;
               end else begin
                  stalls++;
                  prev_stall = 1'b1;
                  prev_cmd   = got;
               end
            end else begin
               if (prev_stall) chk("valid_drop", 32'(nz_valid), 32'd1);
               prev_stall = 1'b0;
            end
         end
      end
   end

   task automatic run_case(input string nm, input int rmode, input int mid_start);
      bit got_done;
      int exp_cyc;
      build_model();
      mode       = rmode;
      accepts    = 0;
      stalls     = 0;
      prev_stall = 1'b0;
      mon_en     = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      got_done = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         start = (c == mid_start);
         @(posedge clk); #1;
      end
      start  = 1'b0;
      mon_en = 1'b0;
      chk({nm, "_done"}, 32'(got_done), 32'd1);
      exp_cyc = 1 + 2 * NROWS + exp_n + stalls;
      chk({nm, "_accepts"}, 32'(accepts), 32'(exp_n));
      chk({nm, "_left"}, 32'(exp_q.size()), 32'd0);
      chk({nm, "_err"}, 32'(err), 32'(exp_err));
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_cycles"}, 32'(cycle_count), 32'(exp_cyc));
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_hold_done"}, 32'(done), 32'd1);
      chk({nm, "_hold_cycles"}, 32'(cycle_count), 32'(exp_cyc));
      chk({nm, "_hold_err"}, 32'(err), 32'(exp_err));
   endtask

   task automatic set_uniform();
      for (int r = 0; r <= NROWS; r++) ptr[r] = 4 * r;
   endtask

   initial begin
      bit hit;
      set_uniform();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_valid", 32'(nz_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_cycles", 32'(cycle_count), 32'd0);
      chk("rst_rp_addr", 32'(rp_addr), 32'd0);

      // Uniform 4 nnz per row, no backpressure; start pulsed mid-run is ignored.
      set_uniform();
      build_model();
      chk("model_uniform_n", 32'(exp_n), 32'd64);
      run_case("uniform", 0, 30);
      chk("uniform_cycles_97", 32'(cycle_count), 32'd97);

      // Restart from DONE gives the identical run.
      run_case("restart", 0, -1);
      chk("restart_cycles_97", 32'(cycle_count), 32'd97);

      // Backpressure 1,0,0,1.
      run_case("backpressure", 1, -1);
      chk("bp_stalled", 32'(stalls > 0), 32'd1);

      // Empty row 3.
      for (int r = 0; r <= NROWS; r++) ptr[r] = (r <= 3) ? 4 * r : 4 * (r - 1);
      build_model();
      chk("model_empty_cmd12", 32'(exp_q[12]), 32'({7'd12, 4'd3, 1'b1, 1'b1}));
      chk("model_empty_cmd13", 32'(exp_q[13]), 32'({7'd12, 4'd4, 1'b0, 1'b0}));
      run_case("empty_row", 0, -1);
      chk("empty_row_cycles_94", 32'(cycle_count), 32'd94);

      // Malformed pointers: ptr[6] < ptr[5].
      set_uniform();
      ptr[6] = 18;
      build_model();
      chk("model_bad_n", 32'(exp_n), 32'd65);
      chk("model_bad_err", 32'(exp_err), 32'd1);
      run_case("malformed", 2, -1);

      // Reset after 10 accepts, then a clean run.
      set_uniform();
      build_model();
      mode = 0; accepts = 0; stalls = 0; prev_stall = 1'b0; mon_en = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk); #2;
         if (accepts >= 10) begin
            hit = 1'b1;
            break;
         end
      end
      mon_en = 1'b0;
      chk("midrst_reached", 32'(hit), 32'd1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_valid", 32'(nz_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_cycles", 32'(cycle_count), 32'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("midrst_idle_valid", 32'(nz_valid), 32'd0);
      run_case("after_reset", 0, -1);

      // Random nondecreasing tables with random backpressure.
      for (int t = 0; t < 4; t++) begin
         ptr[0] = $urandom_range(0, 5);
         for (int r = 1; r <= NROWS; r++) ptr[r] = ptr[r-1] + $urandom_range(0, 6);
         run_case("random", 2, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/csr_row_sequencer.md
Name: csr_row_sequencer

Overview:
Control block for the CSR sparse-matrix-times-vector datapath (S*v = d).
- Walks the row-pointer RAM and issues one command per nonzero (element index, row, last flag) to the column-index/S/vector/MAC pipeline through a valid/ready handshake.
- Flags empty rows so downstream still writes a zero to d.
- Reports busy/done/error and a cycle count.
- Replaces ad-hoc address arithmetic inside the datapath with an explicit FSM.

Parameters:
NROWS, 16, number of matrix rows; the row-pointer RAM holds NROWS+1 entries.
ROW_W, 4, width of the row index; must satisfy 2^ROW_W >= NROWS.
NNZ_W, 7, width of row-pointer values and element indices (max nnz 64 at 25% density).
CNT_W, 12, width of the cycle counter.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  run request; sampled only in IDLE or DONE
rp_addr  out  ROW_W+1  row-pointer RAM read address
rp_data  in  NNZ_W  row-pointer RAM read data; synchronous, valid the cycle after rp_addr
nz_valid  out  1  command valid
nz_ready  in  1  datapath accepts command
nz_idx  out  NNZ_W  element index into column/S RAMs
nz_row  out  ROW_W  row the element belongs to (d address)
nz_last  out  1  last command of the row; downstream writes back and clears the MAC
nz_empty  out  1  row has no nonzeros; downstream writes 0 to d[nz_row]
busy  out  1  high in any state except IDLE and DONE
done  out  1  high while in DONE
err  out  1  sticky; set when ptr[r+1] < ptr[r]
cycle_count  out  CNT_W  cycles spent busy in the last or current run

Behaviour:
- Reset (synchronous, any state): state=IDLE; nz_valid=0, done=0, busy=0, err=0, cycle_count=0, rp_addr=0, row=0, base=0, cur=0, end=0.
- IDLE: rp_addr=0. start=1 -> BASE, cycle_count<=0, err<=0, row<=0.
- BASE (1 cycle): rp_addr=0 -> PTR, with first=1.
- PTR (1 cycle):
  - rp_addr=row+1.
  - If first, base<=rp_data (ptr[0]) and cur<=rp_data.
  - -> CHK.
- CHK (1 cycle): end<=rp_data (ptr[row+1]).
  - rp_data>base -> ISSUE.
  - rp_data==base -> EMPTY.
  - rp_data<base -> err<=1, -> EMPTY.
- ISSUE: nz_valid=1, nz_idx=cur, nz_row=row, nz_last=(cur==end-1), nz_empty=0.
  - On nz_valid&&nz_ready with !nz_last: cur<=cur+1.
  - With nz_last: if row==NROWS-1 -> DONE. Else row<=row+1, base<=end, cur<=end, first=0, -> PTR.
- EMPTY: nz_valid=1, nz_last=1, nz_empty=1, nz_idx=base.
  - On accept, same row-advance rule as the ISSUE last element.
  - For the erroneous row only: base<=cur (pointer not advanced).
- DONE: done=1, busy=0. start=1 -> BASE (new run); otherwise hold.
- Handshake:
  - While nz_valid=1 and nz_ready=0, all nz_* outputs are held stable.
  - nz_valid never drops without acceptance except on reset.
  - nz_ready is ignored when nz_valid=0.
- Throughput, nz_ready tied high:
  - 1 command per cycle within a row.
  - Per-row overhead 2 cycles (PTR, CHK); an empty row costs 3.
  - BASE adds 1 per run.
- cycle_count: +1 on every clock edge where busy=1. Saturates at all-ones. Holds in DONE until the next start or reset.
- start while busy: ignored.
- Reset mid-run: aborts immediately; no further nz_valid.
- Index width: nz_idx wraps modulo 2^NNZ_W; ptr[NROWS]=64 with NNZ_W=7 is legal.

Test Plan:
- Uniform: ptr = 0,4,8,...,64, nz_ready=1, start pulse -> 64 commands, nz_idx 0..63 in order; nz_last at idx 3,7,...,63 with nz_row 0..15; done in the cycle after the last accept; cycle_count=97.
- Empty rows: ptr[3]=ptr[4]=12, rows 0-2 at 4 nnz -> row 3 produces one command with nz_empty=1, nz_last=1, nz_row=3; next command has nz_idx=12, nz_row=4; err=0.
- Backpressure: nz_ready toggles 1,0,0,1 repeating -> every command is held stable through stalls; the index sequence is identical to the uniform case; cycle_count grows by the stall count.
- Malformed pointers: ptr[5]=20, ptr[6]=18 -> err=1 (sticky); row 5 emitted as empty; run completes with done=1.
- Reset mid-run: reset asserted after 10 accepts -> next cycle nz_valid=0, busy=0, cycle_count=0; a later start gives a clean run from nz_idx 0.
- Start during busy and restart from DONE: start pulsed mid-run is ignored (single run of 64 commands); start while in DONE begins a new identical run.
